// File: rtl/button_conditioner.sv
// Four-channel pushbutton conditioner: 2-flop synchronizer, per-channel debounce FSM,
// press pulse, sticky press flags cleared by the processor read strobe.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] raw_buttons,
    input  logic       sticky_mode,
    input  logic       rd_strobe,
    output logic [3:0] buttons,
    output logic [3:0] press_pulse,
    output logic [3:0] pressed,
    output logic [3:0] data_out
);

    typedef enum logic [1:0] {STABLE0, WAIT1, STABLE1, WAIT0} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    state_t           r_state [4];
    logic [CNT_W-1:0] r_cnt   [4];
    logic [3:0]       r_buttons;
    logic [3:0]       r_press_pulse;
    logic [3:0]       r_pressed;
    logic [3:0]       w_rise;
    logic             w_clear;

    // A rising acceptance drives the pulse and the sticky flag on the same edge as buttons.
    always_comb begin
        w_rise = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_rise[i] = (r_state[i] == WAIT1) && r_sync2[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    assign w_clear = rd_strobe && sticky_mode;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_buttons;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_state[i] <= STABLE0;
                r_cnt[i]   <= '0;
            end
            r_buttons     <= '0;
            r_press_pulse <= '0;
            r_pressed     <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                case (r_state[i])
                    STABLE0: begin
                        if (r_sync2[i]) begin
                            r_state[i] <= WAIT1;
                            r_cnt[i]   <= '0;
                        end
                    end
                    WAIT1: begin
                        if (!r_sync2[i]) begin
                            r_state[i] <= STABLE0;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_state[i]   <= STABLE1;
                            r_cnt[i]     <= '0;
                            r_buttons[i] <= 1'b1;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                    STABLE1: begin
                        if (!r_sync2[i]) begin
                            r_state[i] <= WAIT0;
                            r_cnt[i]   <= '0;
                        end
                    end
                    WAIT0: begin
                        if (r_sync2[i]) begin
                            r_state[i] <= STABLE1;
                            r_cnt[i]   <= '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_state[i]   <= STABLE0;
                            r_cnt[i]     <= '0;
                            r_buttons[i] <= 1'b0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state[i] <= STABLE0;
                        r_cnt[i]   <= '0;
                    end
                endcase
            end
            r_press_pulse <= w_rise;
            // Set wins over a simultaneous read-clear so no press is lost.
            r_pressed     <= (r_pressed & ~{4{w_clear}}) | w_rise;
        end
    end

    assign buttons     = r_buttons;
    assign press_pulse = r_press_pulse;
    assign pressed     = r_pressed;
    assign data_out    = sticky_mode ? r_pressed : r_buttons;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized bouncing inputs,
// all checked every cycle against a sliding-window debounce reference model.
module tb_button_conditioner;

    localparam int DEB = 16;

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic [3:0] raw_buttons = '0;
    logic       sticky_mode = 1'b0;
    logic       rd_strobe   = 1'b0;
    logic [3:0] buttons;
    logic [3:0] press_pulse;
    logic [3:0] pressed;
    logic [3:0] data_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    button_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clock       (clock),
        .reset       (reset),
        .raw_buttons (raw_buttons),
        .sticky_mode (sticky_mode),
        .rd_strobe   (rd_strobe),
        .buttons     (buttons),
        .press_pulse (press_pulse),
        .pressed     (pressed),
        .data_out    (data_out)
    );

    // Reference: a level is accepted once the last DEB+1 synchronized samples all agree
    // and differ from the current level; raw reaches the channel logic two edges late.
    logic [DEB:0] m_win [4];
    logic [3:0]   m_d1, m_d2;
    logic [3:0]   m_btn, m_pulse, m_pressed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_d1 = '0; m_d2 = '0; m_btn = '0; m_pulse = '0; m_pressed = '0;
        for (int c = 0; c < 4; c++) m_win[c] = '0;
    endtask

    task automatic model_edge();
        logic [3:0] sync;
        logic [3:0] rise;
        sync = m_d2;
        m_d2 = m_d1;
        m_d1 = raw_buttons;
        rise = '0;
        for (int c = 0; c < 4; c++) begin
            m_win[c] = {m_win[c][DEB-1:0], sync[c]};
            if (m_win[c] == '1 && !m_btn[c]) begin
                m_btn[c] = 1'b1;
                rise[c]  = 1'b1;
            end else if (m_win[c] == '0 && m_btn[c]) begin
                m_btn[c] = 1'b0;
            end
        end
        m_pulse   = rise;
        m_pressed = (m_pressed & ~{4{rd_strobe && sticky_mode}}) | rise;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".buttons"}, 32'(buttons), 32'(m_btn));
        check_eq({tag, ".pulse"},   32'(press_pulse), 32'(m_pulse));
        check_eq({tag, ".pressed"}, 32'(pressed), 32'(m_pressed));
        check_eq({tag, ".data_out"}, 32'(data_out), 32'(sticky_mode ? m_pressed : m_btn));
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_clear();
        else model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        #1;
        model_clear();
        check_all("rst_async");
        steps(n);
        reset = 1'b0;
    endtask

    // First step is the edge that first samples the new raw level; then count edges to acceptance.
    task automatic wait_rise(input int ch, output int n);
        step();
        n = 0;
        while (!buttons[ch] && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        int         n;
        int         hold [4];
        logic       moved;
        logic [3:0] b0;

        model_clear();
        #2;
        check_all("rst_init");
        steps(3);
        reset = 1'b0;

        // Single press latency, pulse, sticky flag
        raw_buttons = 4'b0001;
        wait_rise(0, n);
        check_eq("lat_ch0", 32'(n), 32'(DEB + 2));
        check_eq("pulse_ch0", 32'(press_pulse), 32'h1);
        check_eq("pressed_ch0", 32'(pressed), 32'h1);
        step();
        check_eq("pulse_one_cycle", 32'(press_pulse), 32'h0);
        raw_buttons = '0;
        steps(25);

        // Exactly DEB raw cycles high: too short, rejected
        raw_buttons = 4'b0001;
        steps(DEB);
        raw_buttons = '0;
        b0 = buttons;
        moved = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (buttons !== b0) moved = 1'b1;
        end
        check_eq("short_reject", 32'(moved), 32'h0);

        // Reset mid-debounce discards the pending press
        pulse_reset(2);
        raw_buttons = 4'b0001;
        steps(13);
        pulse_reset(3);
        check_eq("rst_mid_btn", 32'(buttons), 32'h0);
        wait_rise(0, n);
        check_eq("lat_after_rst", 32'(n), 32'(DEB + 2));
        check_eq("pulse_after_rst", 32'(press_pulse), 32'h1);
        step();
        check_eq("pulse_after_rst_end", 32'(press_pulse), 32'h0);

        // All four channels accepted on the same edge
        pulse_reset(2);
        raw_buttons = 4'b1111;
        wait_rise(0, n);
        check_eq("all_btn", 32'(buttons), 32'hF);
        check_eq("all_pulse", 32'(press_pulse), 32'hF);
        raw_buttons = '0;
        steps(40);

        // Channel 2 toggling every 5 cycles never accepted, then held
        moved = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k % 5 == 0) raw_buttons[2] = ~raw_buttons[2];
            step();
            if (buttons[2]) moved = 1'b1;
        end
        check_eq("toggle_reject", 32'(moved), 32'h0);
        raw_buttons[2] = 1'b1;
        wait_rise(2, n);
        check_eq("toggle_hold_lat", 32'(n), 32'(DEB + 2));
        check_eq("toggle_hold_btn", 32'(buttons), 32'h4);
        check_eq("toggle_hold_pulse", 32'(press_pulse), 32'h4);
        raw_buttons = '0;
        steps(40);

        // Sticky read: flags shown until the strobe edge, cleared after
        sticky_mode = 1'b1;
        rd_strobe   = 1'b1;
        step();
        rd_strobe   = 1'b0;
        raw_buttons = 4'b0010;
        wait_rise(1, n);
        raw_buttons = '0;
        steps(25);
        check_eq("sticky_shown", 32'(data_out), 32'h2);
        rd_strobe = 1'b1;
        #1;
        check_eq("sticky_pre_edge", 32'(data_out), 32'h2);
        step();
        rd_strobe = 1'b0;
        check_eq("sticky_cleared", 32'(data_out), 32'h0);

        // Strobe on the acceptance edge: set wins
        raw_buttons = 4'b1000;
        steps(DEB + 2);
        rd_strobe = 1'b1;
        step();
        rd_strobe = 1'b0;
        check_eq("setwin_btn", 32'(buttons), 32'h8);
        check_eq("setwin_pressed", 32'(pressed), 32'h8);

        // Strobe with sticky_mode=0 leaves flags alone
        sticky_mode = 1'b0;
        rd_strobe   = 1'b1;
        steps(3);
        rd_strobe   = 1'b0;
        check_eq("nosticky_keep", 32'(pressed), 32'h8);
        check_eq("nosticky_data", 32'(data_out), 32'(buttons));

        // Random bouncing: mostly short glitches, some holds around the debounce boundary
        for (int c = 0; c < 4; c++) hold[c] = 0;
        for (int k = 0; k < 5000; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    raw_buttons[c] = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 40))
                                                          : int'($urandom_range(1, 6));
                end else begin
                    hold[c]--;
                end
            end
            rd_strobe = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) sticky_mode = ~sticky_mode;
            #1;
            check_eq("mux_comb", 32'(data_out), 32'(sticky_mode ? m_pressed : m_btn));
            if ($urandom_range(0, 999) == 0) pulse_reset(2);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, meaning consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Parameter: CNT_W, default clog2(DEBOUNCE_CYCLES), meaning debounce counter width; never overridden by instantiator.
REQ-003 Port: clock  input  1  system clock; all state is updated on its rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: raw_buttons  input  4  asynchronous, bouncing pushbutton levels; 1 = pressed.
REQ-006 Port: sticky_mode  input  1  selects data_out source: 0 = debounced level, 1 = sticky press flags.
REQ-007 Port: rd_strobe  input  1  processor input-read strobe (uP IN-port bus enable); clears sticky flags.
REQ-008 Port: buttons  output  4  debounced level per channel.
REQ-009 Port: press_pulse  output  4  one-cycle pulse per channel on each accepted 0->1 transition.
REQ-010 Port: pressed  output  4  sticky press flags.
REQ-011 Port: data_out  output  4  value presented to the uP pushbuttons input; combinational mux of buttons/pressed by sticky_mode.

Function
REQ-012 Each channel SHALL pass raw_buttons[i] through a 2-flop synchronizer; only the second flop output (sync[i]) feeds channel logic.
REQ-013 Each channel SHALL run an independent FSM with states STABLE0, WAIT1, STABLE1, WAIT0 and a CNT_W-bit counter.
REQ-014 STABLE0: sync=1 -> WAIT1, cnt<=0; else stay. STABLE1: sync=0 -> WAIT0, cnt<=0; else stay.
REQ-015 WAIT1: sync=0 -> STABLE0 (bounce rejected), cnt<=0; sync=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1; sync=1 and cnt=DEBOUNCE_CYCLES-1 -> STABLE1, buttons[i]<=1.
REQ-016 WAIT0 SHALL mirror WAIT1 with polarities swapped, returning to STABLE1 on bounce and going to STABLE0 with buttons[i]<=0 on acceptance.
REQ-017 Latency: a raw level held steady from the edge that first samples it SHALL appear on buttons exactly DEBOUNCE_CYCLES+2 rising edges later (18 at default).
REQ-018 Any excursion shorter than DEBOUNCE_CYCLES synchronized samples SHALL leave buttons unchanged.
REQ-019 press_pulse[i] SHALL be 1 for exactly the one cycle following the edge on which buttons[i] goes 0->1; no pulse on 1->0.
REQ-020 pressed[i] SHALL set on the edge buttons[i] goes 0->1 and clear on a rising edge where rd_strobe=1 and sticky_mode=1.
REQ-021 Simultaneous set and clear of pressed[i] on the same edge: set SHALL win (press never lost).
REQ-022 rd_strobe with sticky_mode=0 SHALL NOT modify pressed.
REQ-023 rd_strobe held high multiple cycles SHALL clear every cycle; set-wins rule still applies each cycle.
REQ-024 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-025 data_out SHALL equal pressed when sticky_mode=1, buttons when sticky_mode=0, with no added latency.

Reset
REQ-026 While reset=1, synchronizer flops, counters, buttons, press_pulse, pressed SHALL be 0 and every FSM SHALL be in STABLE0, independent of clock.
REQ-027 Reset asserted mid-debounce SHALL discard the pending transition; after release a still-held button requires the full DEBOUNCE_CYCLES+2 edges and produces one press_pulse.
REQ-028 After reset release, a raw_buttons already at 1 SHALL be treated as a new press.

Verification
REQ-029 DEBOUNCE_CYCLES=16, raw_buttons 0000->0001 held -> buttons=0001 exactly 18 edges later, press_pulse=0001 one cycle, pressed=0001.
REQ-030 raw_buttons[2] toggled every 5 cycles for 100 cycles, then held 1 -> no buttons[2] change during toggling; one press_pulse after hold; channels 0,1,3 stay 0.
REQ-031 sticky_mode=1, press ch1 and release, then rd_strobe one cycle -> data_out=0010 until strobe edge, 0000 after.
REQ-032 sticky_mode=1, rd_strobe on same edge ch3 accepts 0->1 -> pressed[3]=1 after that edge.
REQ-033 Reset pulsed at cnt=10 of WAIT1 with raw held 1 -> buttons stays 0 during reset; 1 at 18 edges after release; single press_pulse.
REQ-034 All four channels pressed on the same cycle -> buttons=1111 and press_pulse=1111 on the same edge.
